// File: rtl/camera_capture_if.sv
// Camera-pin and frame-buffer-write bundle for camera_capture; line_err exists only
// when CAMERA_CAPTURE_LINE_CHECK_EN is defined.
interface camera_capture_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  v_sync;
  logic                  h_ref;
  logic [7:0]            data_in;
  logic                  we;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  pixel;
  logic [7:0]            Y;
  logic                  frame_done;
`ifdef CAMERA_CAPTURE_LINE_CHECK_EN
  logic                  line_err;

  modport master (
    output v_sync, h_ref, data_in,
    input  we, write_addr, pixel, Y, frame_done, line_err
  );

  modport slave (
    input  v_sync, h_ref, data_in,
    output we, write_addr, pixel, Y, frame_done, line_err
  );
`else
  modport master (
    output v_sync, h_ref, data_in,
    input  we, write_addr, pixel, Y, frame_done
  );

  modport slave (
    input  v_sync, h_ref, data_in,
    output we, write_addr, pixel, Y, frame_done
  );
`endif
endinterface

// File: rtl/camera_capture.sv
// OV7670 YUV422 capture: 2:1 decimation in both axes, 1-bit luma threshold, 2-pclk write latency,
// no backpressure (frame RAM always accepts). CAMERA_CAPTURE_LINE_CHECK_EN adds line_err.
module camera_capture #(
  parameter int         ADDR_WIDTH  = 15,
  parameter int         H_PIXELS_IN = 320,
  parameter int         V_LINES_IN  = 240,
  parameter logic [7:0] THRESHOLD   = 8'd64,
  parameter bit         Y_FIRST     = 1'b1
) (
  input logic             pclk,
  input logic             reset,
  camera_capture_if.slave bus
);

  localparam int HCW         = $clog2(H_PIXELS_IN + 1) + 1;
  localparam int VCW         = $clog2(V_LINES_IN + 1) + 1;
  localparam int FRAME_WORDS = (H_PIXELS_IN / 2) * (V_LINES_IN / 2);

  localparam logic [HCW-1:0]        H_MAX      = HCW'(H_PIXELS_IN);
  localparam logic [VCW-1:0]        V_MAX      = VCW'(V_LINES_IN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(FRAME_WORDS);
  localparam logic                  LUMA_PHASE = Y_FIRST ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    S_WAIT_VS_HIGH,
    S_WAIT_VS_LOW,
    S_ACTIVE
  } state_t;

  state_t                r_state;
  logic                  r_vs;
  logic                  r_href;
  logic                  r_href_d;
  logic [7:0]            r_data;
  logic                  r_phase;
  logic [HCW-1:0]        r_h_pix;
  logic [VCW-1:0]        r_v_line;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic                  r_pixel;
  logic [7:0]            r_y;
  logic                  r_frame_done;

  logic w_keep;
  logic w_href_fall;

  assign w_keep = !r_h_pix[0] && !r_v_line[0] && (r_h_pix < H_MAX) &&
                  (r_v_line < V_MAX) && (r_next_addr < ADDR_LIMIT);
  assign w_href_fall = r_href_d && !r_href;

`ifdef CAMERA_CAPTURE_LINE_CHECK_EN
  logic r_line_err;
  logic w_line_bad;

  // Byte count of the finished line is {h_pix, phase}; anything but 2*H_PIXELS_IN is an error.
  assign w_line_bad   = (r_h_pix != H_MAX) || r_phase;
  assign bus.line_err = r_line_err;
`endif

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state      <= S_WAIT_VS_HIGH;
      r_vs         <= 1'b0;
      r_href       <= 1'b0;
      r_href_d     <= 1'b0;
      r_data       <= 8'd0;
      r_phase      <= 1'b0;
      r_h_pix      <= '0;
      r_v_line     <= '0;
      r_next_addr  <= '0;
      r_we         <= 1'b0;
      r_write_addr <= '0;
      r_pixel      <= 1'b0;
      r_y          <= 8'd0;
      r_frame_done <= 1'b0;
`ifdef CAMERA_CAPTURE_LINE_CHECK_EN
      r_line_err   <= 1'b0;
`endif
    end else begin
      r_vs         <= bus.v_sync;
      r_href       <= bus.h_ref;
      r_data       <= bus.data_in;
      r_href_d     <= r_href;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef CAMERA_CAPTURE_LINE_CHECK_EN
      if (r_frame_done) r_line_err <= 1'b0;
`endif
      case (r_state)
        S_WAIT_VS_HIGH: begin
          r_phase <= 1'b0;
          r_h_pix <= '0;
          if (r_vs) r_state <= S_WAIT_VS_LOW;
        end
        S_WAIT_VS_LOW: begin
          r_phase     <= 1'b0;
          r_h_pix     <= '0;
          r_v_line    <= '0;
          r_next_addr <= '0;
          if (!r_vs) r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (r_vs) begin
            // Frame end wins over any byte registered on the same cycle.
            r_frame_done <= 1'b1;
            r_next_addr  <= '0;
            r_phase      <= 1'b0;
            r_h_pix      <= '0;
            r_state      <= S_WAIT_VS_LOW;
`ifdef CAMERA_CAPTURE_LINE_CHECK_EN
            if (r_v_line != V_MAX) r_line_err <= 1'b1;
`endif
          end else if (r_href) begin
            r_phase <= ~r_phase;
            if (r_phase && !(&r_h_pix)) r_h_pix <= r_h_pix + 1'b1;
            if ((r_phase == LUMA_PHASE) && w_keep) begin
              r_we         <= 1'b1;
              r_write_addr <= r_next_addr;
              r_y          <= r_data;
              r_pixel      <= (r_data >= THRESHOLD);
              r_next_addr  <= r_next_addr + 1'b1;
            end
          end else begin
            r_phase <= 1'b0;
            r_h_pix <= '0;
            if (w_href_fall) begin
              if (!(&r_v_line)) r_v_line <= r_v_line + 1'b1;
`ifdef CAMERA_CAPTURE_LINE_CHECK_EN
              if (w_line_bad) r_line_err <= 1'b1;
`endif
            end
          end
        end
        default: r_state <= S_WAIT_VS_HIGH;
      endcase
    end
  end

  assign bus.we         = r_we;
  assign bus.write_addr = r_write_addr;
  assign bus.pixel      = r_pixel;
  assign bus.Y          = r_y;
  assign bus.frame_done = r_frame_done;

endmodule

// File: doc/camera_capture.md
Name: camera_capture

Overview:
- Front-end capture stage for the OV7670 camera. It runs in the camera pixel clock domain and sits between the camera pins and the frame buffer write port.
- Parses the YUV422 QVGA byte stream using v_sync/h_ref framing. Decimates 2:1 in both axes to QQVGA (160x120) and thresholds luma to 1 bit.
- Issues single-cycle frame buffer writes (we, write_addr, pixel) that the camera controller forwards to the dual-port frame RAM.

Parameters:
- ADDR_WIDTH, 15, frame buffer address width (160x120 = 19200 words).
- H_PIXELS_IN, 320, input pixels per line (2 bytes each).
- V_LINES_IN, 240, input lines per frame.
- THRESHOLD, 8'd64, luma threshold: Y >= THRESHOLD gives pixel=1 (white), otherwise 0 (black).
- Y_FIRST, 1, 1: Y is the first byte of each pixel pair (YUYV); 0: Y is the second byte (UYVY).

Ports:
- pclk, input, 1, camera pixel clock; the only clock, rising edge.
- reset, input, 1, synchronous, active-high reset.
- v_sync, input, 1, camera frame sync, high during vertical blanking.
- h_ref, input, 1, camera line valid, high while line bytes are valid.
- data_in, input, 8, camera data byte.
- we, output, 1, frame buffer write strobe, one pclk cycle per output pixel.
- write_addr, output, ADDR_WIDTH, frame buffer address, valid when we=1.
- pixel, output, 1, thresholded pixel, valid when we=1.
- Y, output, 8, raw luma of the written pixel, valid when we=1.
- frame_done, output, 1, one-cycle pulse at end of each captured frame.

Behaviour:
- Clock and reset: one clock (pclk); reset is synchronous and active-high.
- Reset values: we=0, write_addr=0, pixel=0, Y=0, frame_done=0; FSM in S_WAIT_VS_HIGH; all counters 0.
- Input register: v_sync, h_ref and data_in are registered once on pclk. All decisions use the registered copies.
- FSM states:
  - S_WAIT_VS_HIGH: wait for registered v_sync=1, then go to S_WAIT_VS_LOW. This guarantees capture never starts mid-frame.
  - S_WAIT_VS_LOW: hold address and line counters at 0; on v_sync=0 go to S_ACTIVE.
  - S_ACTIVE: capture bytes. On a v_sync rising edge: pulse frame_done for one cycle, reset next address to 0, go to S_WAIT_VS_LOW.
- Byte phase: toggles on each cycle with h_ref=1 and is forced to 0 when h_ref=0.
  - Phase 0 completes on byte 0, phase 1 completes the pixel pair.
  - A partial pixel at an h_ref fall (odd byte count) is discarded.
- Counters:
  - h_pix counts input pixels in the line; cleared when h_ref=0.
  - v_line increments on each h_ref falling edge while in S_ACTIVE.
- Keep rule: a pixel is kept iff h_pix[0]=0, v_line[0]=0, h_pix < H_PIXELS_IN and v_line < V_LINES_IN.
- Luma byte: phase 0 when Y_FIRST=1, phase 1 when Y_FIRST=0.
- Write timing:
  - When the luma byte of a kept pixel is on data_in with h_ref=1 before pclk edge N, the outputs are driven after edge N+1 for exactly one cycle: we=1, write_addr=next_addr, Y=byte, pixel=(byte>=THRESHOLD).
  - Latency is 2 pclk cycles.
  - next_addr increments after each write.
- Address bound: writes are suppressed once next_addr reaches 19200 (160*120). There is no wrap within a frame; the address returns to 0 only at frame end.
- Idle outputs: when we=0, write_addr, pixel and Y hold their last values.
- Simultaneous events: v_sync rising while h_ref=1 is treated as frame end. The in-flight byte is dropped; a write already registered still completes.
- Reset mid-frame: any pending write is cancelled. There are no writes until a full v_sync high-to-low sequence has been seen.

Optional Feature:
- Macro: CAMERA_CAPTURE_LINE_CHECK_EN.
- Enabled:
  - Adds output line_err (1 bit, reset 0).
  - On each h_ref falling edge in S_ACTIVE, line_err is set if the byte count of the line differs from 2*H_PIXELS_IN.
  - line_err is sticky until the next frame_done, and clears on the cycle after frame_done.
  - Also sticky-sets if the line count at frame end differs from V_LINES_IN.
- Disabled: no line_err port and no byte-count logic; behaviour is otherwise identical.

Test Plan:
- Full frame: reset, v_sync high then low, 240 lines of 640 bytes with Y=line index -> exactly 19200 we pulses, write_addr 0..19199 contiguous, one frame_done pulse at v_sync rise.
- Threshold: kept pixels with Y=63 and Y=64, THRESHOLD=64 -> pixel=0 then pixel=1; Y output equals input byte; we asserted exactly 2 cycles after the luma byte.
- Byte order: Y_FIRST=0 with UYVY stream U=8'h00, Y=8'hFF -> all written pixel=1 and Y=8'hFF.
- Mid-frame start: release reset with h_ref toggling and v_sync=0 -> zero writes until v_sync pulses high then low; first write then has write_addr=0.
- Oversize/short: a 260-line frame -> writes stop at address 19199; a line with 641 bytes -> the last odd byte is discarded. With CAMERA_CAPTURE_LINE_CHECK_EN, line_err=1 until one cycle after frame_done.
- Reset mid-write: assert reset on the cycle the luma byte is registered -> no we pulse; all outputs return to 0.
